// File: rtl/data_memory_ls.sv
// Byte-addressed data memory for the RV32I load/store unit: sized loads/stores with
// sign/zero extension, fault reporting and a fixed-latency, in-order response pipeline.
module data_memory_ls #(
    parameter int    HEIGHT         = 256,
    parameter int    ADDR_W         = 32,
    parameter int    READ_LAT       = 1,
    parameter int    CLEAR_ON_RESET = 0,
    parameter string INIT_FILE      = "test.r32i"
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    input  logic [ADDR_W-1:0] i_Addr,
    input  logic [31:0]       i_Wd,
    output logic              o_ready,
    output logic              o_valid,
    output logic [31:0]       o_Rd,
    output logic              o_err
);

    localparam int                IDX_W    = $clog2(HEIGHT);
    localparam logic [ADDR_W:0]   LIMIT    = (ADDR_W + 1)'(HEIGHT);
    localparam logic [IDX_W-1:0]  LAST_CLR = IDX_W'(HEIGHT - 4);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

    logic [7:0]       mem [HEIGHT];

    logic             accept;
    logic             fault;
    logic             load_ok;
    logic             store_ok;
    logic [1:0]       nbytes_m1;
    logic [3:0]       size_mask;
    logic [ADDR_W:0]  last_addr;
    logic [IDX_W-1:0] idx;
    logic [7:0]       rd_byte [4];
    logic [31:0]      load_data;

    logic             wr_en   [4];
    logic [IDX_W-1:0] wr_idx  [4];
    logic [7:0]       wr_byte [4];

    logic             valid_q [READ_LAT];
    logic             valid_d [READ_LAT];
    logic             err_q   [READ_LAT];
    logic             err_d   [READ_LAT];
    logic [31:0]      rd_q, rd_d;
    logic             upd_in;
    logic [31:0]      data_in;

    assign o_ready  = (state_q == S_READY);
    assign accept   = i_req && (state_q == S_READY);
    assign load_ok  = accept && !i_we && !fault;
    assign store_ok = accept && i_we && !fault;
    assign idx      = i_Addr[IDX_W-1:0];

    // The range check runs one bit wider than the address so a high address cannot wrap into range.
    always_comb begin
        nbytes_m1 = 2'd0;
        size_mask = 4'b0001;
        case (i_size)
            2'd1: begin
                nbytes_m1 = 2'd1;
                size_mask = 4'b0011;
            end
            2'd2: begin
                nbytes_m1 = 2'd3;
                size_mask = 4'b1111;
            end
            default: ;
        endcase
        last_addr = {1'b0, i_Addr} + {{(ADDR_W - 1){1'b0}}, nbytes_m1};
        fault = (i_size == 2'd3)
             || ((i_size == 2'd1) && i_Addr[0])
             || ((i_size == 2'd2) && (i_Addr[1:0] != 2'b00))
             || (last_addr >= LIMIT);
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rd_byte[k] = mem[idx + IDX_W'(k)];
        end
        load_data = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
        case (i_size)
            2'd0: load_data = {{24{rd_byte[0][7] & ~i_unsigned}}, rd_byte[0]};
            2'd1: load_data = {{16{rd_byte[1][7] & ~i_unsigned}}, rd_byte[1], rd_byte[0]};
            default: ;
        endcase
    end

    // While clearing, the port is closed, so the clear sequencer owns all four write lanes.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            wr_en[k]   = store_ok && size_mask[k];
            wr_idx[k]  = idx + IDX_W'(k);
            wr_byte[k] = i_Wd[8*k +: 8];
            if (state_q == S_CLEAR) begin
                wr_en[k]   = 1'b1;
                wr_idx[k]  = clr_idx_q + IDX_W'(k);
                wr_byte[k] = 8'h00;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_en[k]) begin
                mem[wr_idx[k]] <= wr_byte[k];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == S_CLEAR) begin
            if (clr_idx_q == LAST_CLR) begin
                state_d = S_READY;
            end else begin
                clr_idx_d = clr_idx_q + IDX_W'(4);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            if (CLEAR_ON_RESET != 0) begin
                state_q <= S_CLEAR;
            end else begin
                state_q <= S_READY;
            end
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Load data needs only READ_LAT-1 stages: the final stage is o_Rd itself, which holds between loads.
    if (READ_LAT > 1) begin : g_chain
        logic        upd_q  [READ_LAT-1];
        logic        upd_d  [READ_LAT-1];
        logic [31:0] ldat_q [READ_LAT-1];
        logic [31:0] ldat_d [READ_LAT-1];

        always_comb begin
            upd_d[0]  = load_ok;
            ldat_d[0] = load_data;
            for (int i = 1; i < READ_LAT - 1; i++) begin
                upd_d[i]  = upd_q[i-1];
                ldat_d[i] = ldat_q[i-1];
            end
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                for (int i = 0; i < READ_LAT - 1; i++) begin
                    upd_q[i]  <= 1'b0;
                    ldat_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < READ_LAT - 1; i++) begin
                    upd_q[i]  <= upd_d[i];
                    ldat_q[i] <= ldat_d[i];
                end
            end
        end

        assign upd_in  = upd_q[READ_LAT-2];
        assign data_in = ldat_q[READ_LAT-2];
    end else begin : g_direct
        assign upd_in  = load_ok;
        assign data_in = load_data;
    end

    always_comb begin
        valid_d[0] = accept;
        err_d[0]   = accept && fault;
        for (int i = 1; i < READ_LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            err_d[i]   = err_q[i-1];
        end
        rd_d = upd_in ? data_in : rd_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < READ_LAT; i++) begin
                valid_q[i] <= 1'b0;
                err_q[i]   <= 1'b0;
            end
            rd_q <= '0;
        end else begin
            for (int i = 0; i < READ_LAT; i++) begin
                valid_q[i] <= valid_d[i];
                err_q[i]   <= err_d[i];
            end
            rd_q <= rd_d;
        end
    end

    assign o_valid = valid_q[READ_LAT-1];
    assign o_err   = err_q[READ_LAT-1];
    assign o_Rd    = rd_q;

endmodule

// File: tb/tb_data_memory_ls.sv
// Directed self-checking bench for data_memory_ls: four instances cover latency 1, 3 and 2
// and the zero-clear-on-reset variant, all sharing one clock and one set of request inputs.
module tb_data_memory_ls;

   logic        clock = 1'b0;
   logic        reset [4];
   logic        req   [4];
   logic        we;
   logic [1:0]  size;
   logic        uns;
   logic [31:0] addr;
   logic [31:0] wd;
   logic        ready [4];
   logic        valid [4];
   logic        err   [4];
   logic [31:0] rd    [4];

   int checks = 0;
   int failures = 0;
   int pulses;
   int zeroCnt;

   // Free-running 10-time-unit clock; the bench drives and samples on the falling edge.
   always #5 clock = ~clock;

   data_memory_ls #(.HEIGHT(256), .ADDR_W(32), .READ_LAT(1), .CLEAR_ON_RESET(0), .INIT_FILE("")) dutLat1 (
      .i_clk(clock), .i_rst(reset[0]), .i_req(req[0]), .i_we(we), .i_size(size), .i_unsigned(uns),
      .i_Addr(addr), .i_Wd(wd), .o_ready(ready[0]), .o_valid(valid[0]), .o_Rd(rd[0]), .o_err(err[0]));

   data_memory_ls #(.HEIGHT(256), .ADDR_W(32), .READ_LAT(3), .CLEAR_ON_RESET(0), .INIT_FILE("")) dutLat3 (
      .i_clk(clock), .i_rst(reset[1]), .i_req(req[1]), .i_we(we), .i_size(size), .i_unsigned(uns),
      .i_Addr(addr), .i_Wd(wd), .o_ready(ready[1]), .o_valid(valid[1]), .o_Rd(rd[1]), .o_err(err[1]));

   data_memory_ls #(.HEIGHT(256), .ADDR_W(32), .READ_LAT(2), .CLEAR_ON_RESET(0), .INIT_FILE("")) dutLat2 (
      .i_clk(clock), .i_rst(reset[2]), .i_req(req[2]), .i_we(we), .i_size(size), .i_unsigned(uns),
      .i_Addr(addr), .i_Wd(wd), .o_ready(ready[2]), .o_valid(valid[2]), .o_Rd(rd[2]), .o_err(err[2]));

   data_memory_ls #(.HEIGHT(256), .ADDR_W(32), .READ_LAT(1), .CLEAR_ON_RESET(1), .INIT_FILE("")) dutClear (
      .i_clk(clock), .i_rst(reset[3]), .i_req(req[3]), .i_we(we), .i_size(size), .i_unsigned(uns),
      .i_Addr(addr), .i_Wd(wd), .o_ready(ready[3]), .o_valid(valid[3]), .o_Rd(rd[3]), .o_err(err[3]));

   // Presents one request to instance d for exactly one rising edge, returning on the next falling edge.
   task automatic applyStimulus(input int d, input logic w, input logic [1:0] s, input logic u,
                                input logic [31:0] a, input logic [31:0] data);
      we = w;
      size = s;
      uns = u;
      addr = a;
      wd = data;
      req[d] = 1'b1;
      @(negedge clock);
      req[d] = 1'b0;
   endtask

   // Compares the response triple {o_valid, o_err, o_Rd} of instance d with the expected triple.
   task automatic checkOutput(input string tag, input int d, input logic expValid, input logic expErr,
                              input logic [31:0] expRd);
      logic [33:0] obs;
      logic [33:0] exp;
      obs = {valid[d], err[d], rd[d]};
      exp = {expValid, expErr, expRd};
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed valid/err/rd=%b/%b/%h expected %b/%b/%h",
                tag, obs[33], obs[32], obs[31:0], expValid, expErr, expRd);
      end
   endtask

   // Compares a scalar observation (ready flag or an event count) with its expected value.
   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Linear directed sequence: reset, latency-1 functional and fault cases, latency-3 streaming,
   // latency-2 reset during a pending load, then the zero-clear instance.
   initial begin
      for (int i = 0; i < 4; i++) begin
         reset[i] = 1'b1;
         req[i] = 1'b0;
      end
      we = 1'b0;
      size = 2'd0;
      uns = 1'b0;
      addr = '0;
      wd = '0;
      repeat (2) @(negedge clock);
      checkOutput("reset_lat1", 0, 1'b0, 1'b0, 32'h0);
      checkOutput("reset_lat3", 1, 1'b0, 1'b0, 32'h0);
      checkValue("reset_ready_noclear", 32'(ready[0]), 32'd1);
      checkValue("reset_ready_clear", 32'(ready[3]), 32'd0);
      for (int i = 0; i < 4; i++) reset[i] = 1'b0;

      applyStimulus(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
      checkOutput("sw_10", 0, 1'b1, 1'b0, 32'h0);
      applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      checkOutput("lw_10", 0, 1'b1, 1'b0, 32'hDEADBEEF);
      applyStimulus(0, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
      checkOutput("lb_13", 0, 1'b1, 1'b0, 32'hFFFFFFDE);
      applyStimulus(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
      checkOutput("lbu_13", 0, 1'b1, 1'b0, 32'h000000DE);
      applyStimulus(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
      checkOutput("lh_12", 0, 1'b1, 1'b0, 32'hFFFFDEAD);
      applyStimulus(0, 1'b0, 2'd1, 1'b1, 32'h10, 32'h0);
      checkOutput("lhu_10", 0, 1'b1, 1'b0, 32'h0000BEEF);
      applyStimulus(0, 1'b0, 2'd0, 1'b1, 32'h10, 32'h0);
      checkOutput("lbu_10", 0, 1'b1, 1'b0, 32'h000000EF);
      applyStimulus(0, 1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
      checkOutput("lbu_11", 0, 1'b1, 1'b0, 32'h000000BE);
      applyStimulus(0, 1'b0, 2'd0, 1'b1, 32'h12, 32'h0);
      checkOutput("lbu_12", 0, 1'b1, 1'b0, 32'h000000AD);
      @(negedge clock);
      checkOutput("idle_no_pulse", 0, 1'b0, 1'b0, 32'h000000AD);

      applyStimulus(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'hA5A5A5A5);
      checkOutput("sw_20", 0, 1'b1, 1'b0, 32'h000000AD);
      applyStimulus(0, 1'b1, 2'd2, 1'b0, 32'h24, 32'h5A5A5A5A);
      applyStimulus(0, 1'b1, 2'd2, 1'b0, 32'hFC, 32'h0BADF00D);
      checkOutput("sw_fc", 0, 1'b1, 1'b0, 32'h000000AD);

      applyStimulus(0, 1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
      checkOutput("fault_lh_11", 0, 1'b1, 1'b1, 32'h000000AD);
      applyStimulus(0, 1'b1, 2'd2, 1'b0, 32'h22, 32'h11223344);
      checkOutput("fault_sw_22", 0, 1'b1, 1'b1, 32'h000000AD);
      applyStimulus(0, 1'b1, 2'd3, 1'b0, 32'h20, 32'h0);
      checkOutput("fault_store_size3", 0, 1'b1, 1'b1, 32'h000000AD);
      applyStimulus(0, 1'b0, 2'd3, 1'b0, 32'h20, 32'h0);
      checkOutput("fault_load_size3", 0, 1'b1, 1'b1, 32'h000000AD);
      applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'hFE, 32'h0);
      checkOutput("fault_lw_fe", 0, 1'b1, 1'b1, 32'h000000AD);
      applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
      checkOutput("fault_lw_100", 0, 1'b1, 1'b1, 32'h000000AD);
      applyStimulus(0, 1'b1, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h0);
      checkOutput("fault_sw_nowrap", 0, 1'b1, 1'b1, 32'h000000AD);

      applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
      checkOutput("readback_20", 0, 1'b1, 1'b0, 32'hA5A5A5A5);
      applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'h24, 32'h0);
      checkOutput("readback_24", 0, 1'b1, 1'b0, 32'h5A5A5A5A);
      applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'hFC, 32'h0);
      checkOutput("readback_fc", 0, 1'b1, 1'b0, 32'h0BADF00D);

      applyStimulus(0, 1'b1, 2'd0, 1'b0, 32'hFF, 32'h000000C3);
      checkOutput("sb_ff_last_byte", 0, 1'b1, 1'b0, 32'h0BADF00D);
      applyStimulus(0, 1'b0, 2'd2, 1'b1, 32'hFC, 32'h0);
      checkOutput("lw_fc_after_sb", 0, 1'b1, 1'b0, 32'hC3ADF00D);
      applyStimulus(0, 1'b0, 2'd1, 1'b0, 32'hFE, 32'h0);
      checkOutput("lh_fe_top_half", 0, 1'b1, 1'b0, 32'hFFFFC3AD);

      applyStimulus(0, 1'b1, 2'd2, 1'b0, 32'h30, 32'h0);
      applyStimulus(0, 1'b1, 2'd1, 1'b0, 32'h30, 32'h1234ABCD);
      applyStimulus(0, 1'b1, 2'd0, 1'b0, 32'h33, 32'hFFFFFF77);
      applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
      checkOutput("partial_stores_30", 0, 1'b1, 1'b0, 32'h7700ABCD);

      applyStimulus(1, 1'b1, 2'd2, 1'b0, 32'h0, 32'h03020100);
      checkOutput("lat3_store_not_early", 1, 1'b0, 1'b0, 32'h0);
      applyStimulus(1, 1'b1, 2'd2, 1'b0, 32'h4, 32'h07060504);
      applyStimulus(1, 1'b1, 2'd2, 1'b0, 32'h8, 32'h0B0A0908);
      checkOutput("lat3_store_resp", 1, 1'b1, 1'b0, 32'h0);
      repeat (3) @(negedge clock);
      checkOutput("lat3_drained", 1, 1'b0, 1'b0, 32'h0);
      applyStimulus(1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
      checkOutput("lat3_wait1", 1, 1'b0, 1'b0, 32'h0);
      applyStimulus(1, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
      checkOutput("lat3_wait2", 1, 1'b0, 1'b0, 32'h0);
      applyStimulus(1, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
      checkOutput("lat3_resp0", 1, 1'b1, 1'b0, 32'h03020100);
      @(negedge clock);
      checkOutput("lat3_resp4", 1, 1'b1, 1'b0, 32'h07060504);
      @(negedge clock);
      checkOutput("lat3_resp8", 1, 1'b1, 1'b0, 32'h0B0A0908);
      @(negedge clock);
      checkOutput("lat3_after", 1, 1'b0, 1'b0, 32'h0B0A0908);

      applyStimulus(2, 1'b1, 2'd2, 1'b0, 32'h40, 32'hFEEDC0DE);
      @(negedge clock);
      applyStimulus(2, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
      checkOutput("lat2_wait", 2, 1'b0, 1'b0, 32'h0);
      @(negedge clock);
      checkOutput("lat2_lw_40", 2, 1'b1, 1'b0, 32'hFEEDC0DE);
      applyStimulus(2, 1'b1, 2'd2, 1'b0, 32'h44, 32'h13579BDF);
      @(negedge clock);
      applyStimulus(2, 1'b0, 2'd2, 1'b0, 32'h44, 32'h0);
      reset[2] = 1'b1;
      #1;
      checkOutput("lat2_in_reset", 2, 1'b0, 1'b0, 32'h0);
      @(negedge clock);
      reset[2] = 1'b0;
      pulses = 0;
      repeat (4) begin
         if (valid[2]) pulses++;
         @(negedge clock);
      end
      checkValue("lat2_no_resp_after_reset", pulses, 0);
      checkOutput("lat2_rd_cleared", 2, 1'b0, 1'b0, 32'h0);
      applyStimulus(2, 1'b0, 2'd2, 1'b0, 32'h44, 32'h0);
      @(negedge clock);
      checkOutput("lat2_retained_44", 2, 1'b1, 1'b0, 32'h13579BDF);

      repeat (64) @(negedge clock);
      checkValue("clear_done_ready", 32'(ready[3]), 32'd1);
      applyStimulus(3, 1'b1, 2'd2, 1'b0, 32'hFC, 32'h89ABCDEF);
      applyStimulus(3, 1'b1, 2'd2, 1'b0, 32'h0, 32'h12345678);
      applyStimulus(3, 1'b0, 2'd2, 1'b0, 32'hFC, 32'h0);
      checkOutput("clear_preload_fc", 3, 1'b1, 1'b0, 32'h89ABCDEF);
      reset[3] = 1'b1;
      @(negedge clock);
      checkValue("clear_ready_in_reset", 32'(ready[3]), 32'd0);
      reset[3] = 1'b0;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin
            we = 1'b0;
            size = 2'd2;
            uns = 1'b0;
            addr = 32'hFC;
            req[3] = 1'b1;
         end else begin
            req[3] = 1'b0;
         end
         if (valid[3]) pulses++;
         @(negedge clock);
      end
      req[3] = 1'b0;
      reset[3] = 1'b1;
      @(negedge clock);
      reset[3] = 1'b0;
      zeroCnt = 0;
      for (int i = 0; i < 64; i++) begin
         if (!ready[3]) zeroCnt++;
         if (valid[3]) pulses++;
         @(negedge clock);
      end
      checkValue("clear_ready_low_cycles", zeroCnt, 64);
      checkValue("clear_ready_after", 32'(ready[3]), 32'd1);
      checkValue("clear_req_ignored", pulses, 0);
      applyStimulus(3, 1'b0, 2'd2, 1'b0, 32'hFC, 32'h0);
      checkOutput("clear_lw_fc", 3, 1'b1, 1'b0, 32'h0);
      applyStimulus(3, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
      checkOutput("clear_lw_00", 3, 1'b1, 1'b0, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
